// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm datapath.
// Used by the alarm bank and by the time-set logic.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   localparam logic [3:0] MAX_MS_HR      = 4'd2;
   localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
   localparam logic [3:0] MAX_MS_MIN     = 4'd5;
   localparam logic [3:0] MAX_LS_DIGIT   = 4'd9;

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } bcd_time_t;

endpackage

// File: rtl/alarm_bank_if.sv
// Keypad/time/speaker-side signal bundle of the alarm bank.
// master = controlling logic, slave = alarm_bank.
interface alarm_bank_if #(
   parameter int NUM_ALARMS = 4,
   parameter int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
   logic                  load_new_alarm;
   logic                  set_enable;
   logic                  enable_value;
   logic [SEL_W-1:0]      alarm_sel;
   logic [3:0]            new_alarm_ms_hr;
   logic [3:0]            new_alarm_ls_hr;
   logic [3:0]            new_alarm_ms_min;
   logic [3:0]            new_alarm_ls_min;
   logic [3:0]            current_time_ms_hr;
   logic [3:0]            current_time_ls_hr;
   logic [3:0]            current_time_ms_min;
   logic [3:0]            current_time_ls_min;
   logic                  minute_tick;
   logic                  stop_alarm;
   logic                  snooze;
   logic [3:0]            alarm_time_ms_hr;
   logic [3:0]            alarm_time_ls_hr;
   logic [3:0]            alarm_time_ms_min;
   logic [3:0]            alarm_time_ls_min;
   logic [NUM_ALARMS-1:0] alarm_enabled;
   logic                  sound_alarm;
   logic [SEL_W-1:0]      active_slot;
   logic                  load_error;

   modport master (
      output load_new_alarm, set_enable, enable_value, alarm_sel,
             new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
             current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
             minute_tick, stop_alarm, snooze,
      input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
             alarm_enabled, sound_alarm, active_slot, load_error
   );

   modport slave (
      input  load_new_alarm, set_enable, enable_value, alarm_sel,
             new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
             current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
             minute_tick, stop_alarm, snooze,
      output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
             alarm_enabled, sound_alarm, active_slot, load_error
   );

endinterface

// File: rtl/alarm_time_check.sv
// Combinational BCD validity check of a 24-hour hh:mm time.
module alarm_time_check
   import alarm_pkg::*;
(
   input  bcd_time_t bcd_in,
   output logic      valid
);

   // Hours 20..23 are the only case where the tens digit limits the units digit.
   assign valid = (bcd_in.ms_hr  <= MAX_MS_HR)
               && (bcd_in.ls_hr  <= MAX_LS_DIGIT)
               && ((bcd_in.ms_hr != MAX_MS_HR) || (bcd_in.ls_hr <= MAX_LS_HR_AT_2))
               && (bcd_in.ms_min <= MAX_MS_MIN)
               && (bcd_in.ls_min <= MAX_LS_DIGIT);

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm store with a ring/snooze controller driving sound_alarm.
module alarm_bank
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 3
)
(
   input  logic         clock,
   input  logic         reset,
   alarm_bank_if.slave  bus
);

   localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

   bcd_time_t             new_time;
   bcd_time_t             cur_time;
   logic                  new_valid;
   bcd_time_t             slot_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] enable_vec;
   logic [NUM_ALARMS-1:0] slot_hit;
   logic [NUM_ALARMS-1:0] active_hit;
   logic [NUM_ALARMS-1:0] match_vec;
   logic [NUM_ALARMS-1:0] other_vec;
   logic                  sel_in_range;
   logic                  load_error_reg;

   alarm_state_t          state_reg, state_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic [SEL_W-1:0]      active_slot_reg, active_slot_next;

   assign new_time = '{ms_hr:  bus.new_alarm_ms_hr,  ls_hr:  bus.new_alarm_ls_hr,
                       ms_min: bus.new_alarm_ms_min, ls_min: bus.new_alarm_ls_min};
   assign cur_time = '{ms_hr:  bus.current_time_ms_hr,  ls_hr:  bus.current_time_ls_hr,
                       ms_min: bus.current_time_ms_min, ls_min: bus.current_time_ls_min};

   alarm_time_check u_new_check (
      .bcd_in (new_time),
      .valid  (new_valid)
   );

   // An out-of-range alarm_sel decodes to no slot at all, which silences
   // writes, readback and load_error in one place.
   generate
      for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
         bcd_time_t time_reg;
         logic      enable_reg;

         assign slot_hit[gi]   = (bus.alarm_sel == SEL_W'(gi));
         assign active_hit[gi] = (active_slot_reg == SEL_W'(gi));

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               time_reg   <= '0;
               enable_reg <= 1'b0;
            end else begin
               if (bus.load_new_alarm && slot_hit[gi] && new_valid)
                  time_reg <= new_time;
               if (bus.set_enable && slot_hit[gi])
                  enable_reg <= bus.enable_value;
            end
         end

         assign slot_time[gi]  = time_reg;
         assign enable_vec[gi] = enable_reg;
         assign match_vec[gi]  = bus.minute_tick && enable_reg && (time_reg == cur_time);
      end
   endgenerate

   assign sel_in_range = |slot_hit;
   assign other_vec    = match_vec & ~active_hit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         load_error_reg <= 1'b0;
      else
         load_error_reg <= bus.load_new_alarm && sel_in_range && !new_valid;
   end

   bcd_time_t readback;

   always_comb begin
      readback = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         if (slot_hit[i])
            readback = slot_time[i];
   end

   // Lowest-index priority encoders: all matches, and matches other than the active slot.
   logic             win_any, other_any;
   logic [SEL_W-1:0] win_idx, other_idx;

   always_comb begin
      win_any   = 1'b0;
      win_idx   = '0;
      other_any = 1'b0;
      other_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (match_vec[i]) begin
            win_any = 1'b1;
            win_idx = SEL_W'(i);
         end
         if (other_vec[i]) begin
            other_any = 1'b1;
            other_idx = SEL_W'(i);
         end
      end
   end

   logic       disable_active;
   logic [3:0] cnt_inc;

   assign disable_active = bus.set_enable && !bus.enable_value && |(slot_hit & active_hit);
   assign cnt_inc        = cnt_reg + 4'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         active_slot_reg <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         active_slot_reg <= active_slot_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      active_slot_next = active_slot_reg;
      unique case (state_reg)
         IDLE: begin
            if (win_any) begin
               state_next       = RING;
               active_slot_next = win_idx;
               cnt_next         = '0;
            end
         end
         RING: begin
            if (bus.stop_alarm || disable_active) begin
               state_next = IDLE;
            end else if (bus.snooze) begin
               state_next = SNOOZE;
               cnt_next   = '0;
            end else if (bus.minute_tick) begin
               if (cnt_inc == 4'(RING_MIN))
                  state_next = IDLE;
               else
                  cnt_next = cnt_inc;
            end
         end
         SNOOZE: begin
            if (bus.stop_alarm || disable_active) begin
               state_next = IDLE;
            end else if (bus.minute_tick) begin
               if (other_any) begin
                  state_next       = RING;
                  active_slot_next = other_idx;
                  cnt_next         = '0;
               end else if (cnt_inc == 4'(SNOOZE_MIN)) begin
                  state_next = RING;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // IDLE always presents a cleared counter and slot 0.
      if (state_next == IDLE) begin
         cnt_next         = '0;
         active_slot_next = '0;
      end
   end

   assign bus.alarm_time_ms_hr  = readback.ms_hr;
   assign bus.alarm_time_ls_hr  = readback.ls_hr;
   assign bus.alarm_time_ms_min = readback.ms_min;
   assign bus.alarm_time_ls_min = readback.ls_min;
   assign bus.alarm_enabled     = enable_vec;
   assign bus.sound_alarm       = (state_reg == RING);
   assign bus.active_slot       = active_slot_reg;
   assign bus.load_error        = load_error_reg;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed scoreboard bench for alarm_bank (4 slots, snooze 5, ring 3).
module tb_alarm_bank;

   localparam int NUM_ALARMS = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q [$];

   always #5 clock = ~clock;

   alarm_bank_if #(.NUM_ALARMS(NUM_ALARMS)) bus ();

   alarm_bank #(
      .NUM_ALARMS (NUM_ALARMS),
      .SNOOZE_MIN (5),
      .RING_MIN   (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%0h expected=none", obs);
      end else begin
         it = sb_q.pop_front();
         checks++;
         assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
         end
         $display("check %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
   endtask

   function automatic logic [31:0] rb_now();
      return {16'h0, bus.alarm_time_ms_hr, bus.alarm_time_ls_hr,
              bus.alarm_time_ms_min, bus.alarm_time_ls_min};
   endfunction

   task automatic load(input logic [1:0] sel, input logic [15:0] t, input logic exp_err);
      push("load_error", {31'h0, exp_err});
      bus.alarm_sel = sel;
      {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = t;
      bus.load_new_alarm = 1'b1;
      cyc();
      bus.load_new_alarm = 1'b0;
      pop_check({31'h0, bus.load_error});
   endtask

   task automatic set_en(input logic [1:0] sel, input logic v);
      bus.alarm_sel    = sel;
      bus.enable_value = v;
      bus.set_enable   = 1'b1;
      cyc();
      bus.set_enable   = 1'b0;
   endtask

   task automatic check_rb(input logic [1:0] sel, input logic [15:0] exp);
      push("readback", {16'h0, exp});
      bus.alarm_sel = sel;
      #1;
      pop_check(rb_now());
   endtask

   task automatic tick(input logic [15:0] t, input logic exp_sound, input logic [1:0] exp_active);
      push("sound_after_tick", {31'h0, exp_sound});
      push("active_after_tick", {30'h0, exp_active});
      {bus.current_time_ms_hr, bus.current_time_ls_hr,
       bus.current_time_ms_min, bus.current_time_ls_min} = t;
      bus.minute_tick = 1'b1;
      cyc();
      bus.minute_tick = 1'b0;
      pop_check({31'h0, bus.sound_alarm});
      pop_check({30'h0, bus.active_slot});
   endtask

   task automatic ctrl(input logic stop, input logic snz, input logic exp_sound);
      push("sound_after_ctrl", {31'h0, exp_sound});
      bus.stop_alarm = stop;
      bus.snooze     = snz;
      cyc();
      bus.stop_alarm = 1'b0;
      bus.snooze     = 1'b0;
      pop_check({31'h0, bus.sound_alarm});
   endtask

   initial begin
      bus.load_new_alarm = 1'b0;
      bus.set_enable     = 1'b0;
      bus.enable_value   = 1'b0;
      bus.alarm_sel      = '0;
      {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = '0;
      {bus.current_time_ms_hr, bus.current_time_ls_hr,
       bus.current_time_ms_min, bus.current_time_ls_min} = 16'h1111;
      bus.minute_tick = 1'b0;
      bus.stop_alarm  = 1'b0;
      bus.snooze      = 1'b0;

      // Reset state
      #12;
      push("rst_sound", 0);      pop_check({31'h0, bus.sound_alarm});
      push("rst_enabled", 0);    pop_check({28'h0, bus.alarm_enabled});
      push("rst_active", 0);     pop_check({30'h0, bus.active_slot});
      push("rst_load_error", 0); pop_check({31'h0, bus.load_error});
      check_rb(2'd3, 16'h0000);
      reset = 1'b0;
      cyc();

      // Slot 2 at 07:30 rings one clock after the matching tick
      load(2'd2, 16'h0730, 1'b0);
      set_en(2'd2, 1'b1);
      check_rb(2'd2, 16'h0730);
      push("enabled_slot2", 32'h4); pop_check({28'h0, bus.alarm_enabled});
      tick(16'h0729, 1'b0, 2'd0);
      tick(16'h0730, 1'b1, 2'd2);
      ctrl(1'b1, 1'b0, 1'b0);
      push("active_after_stop", 0); pop_check({30'h0, bus.active_slot});
      set_en(2'd2, 1'b0);

      // Invalid loads rejected, boundary valid load accepted
      load(2'd1, 16'h2400, 1'b1);
      push("load_error_pulse", 0); cyc(); pop_check({31'h0, bus.load_error});
      load(2'd1, 16'h1260, 1'b1);
      check_rb(2'd1, 16'h0000);
      load(2'd1, 16'h2359, 1'b0);
      check_rb(2'd1, 16'h2359);

      // Snooze for 5 ticks, re-ring, then auto-stop after 3 ticks
      load(2'd0, 16'h0500, 1'b0);
      set_en(2'd0, 1'b1);
      tick(16'h0500, 1'b1, 2'd0);
      ctrl(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++)
         tick(16'h0500 + 16'(i), (i == 5), 2'd0);
      tick(16'h0506, 1'b1, 2'd0);
      tick(16'h0507, 1'b1, 2'd0);
      tick(16'h0508, 1'b0, 2'd0);
      set_en(2'd0, 1'b0);

      // Two slots match: lowest wins; stop beats snooze
      load(2'd1, 16'h0600, 1'b0);
      load(2'd3, 16'h0600, 1'b0);
      set_en(2'd1, 1'b1);
      set_en(2'd3, 1'b1);
      tick(16'h0600, 1'b1, 2'd1);
      ctrl(1'b1, 1'b1, 1'b0);
      push("active_after_both", 0); pop_check({30'h0, bus.active_slot});
      set_en(2'd1, 1'b0);
      set_en(2'd3, 1'b0);

      // Another slot's match during snooze re-rings with that slot
      load(2'd0, 16'h0800, 1'b0);
      load(2'd2, 16'h0802, 1'b0);
      set_en(2'd0, 1'b1);
      set_en(2'd2, 1'b1);
      tick(16'h0800, 1'b1, 2'd0);
      ctrl(1'b0, 1'b1, 1'b0);
      tick(16'h0801, 1'b0, 2'd0);
      tick(16'h0802, 1'b1, 2'd2);
      // Disabling the ringing slot stops it on the same edge
      push("disable_active_sound", 0);
      set_en(2'd2, 1'b0);
      pop_check({31'h0, bus.sound_alarm});

      // Asynchronous reset mid-RING
      tick(16'h0800, 1'b1, 2'd0);
      reset = 1'b1;
      #1;
      push("async_rst_sound", 0);   pop_check({31'h0, bus.sound_alarm});
      push("async_rst_enabled", 0); pop_check({28'h0, bus.alarm_enabled});
      for (int s = 0; s < NUM_ALARMS; s++)
         check_rb(2'(s), 16'h0000);
      reset = 1'b0;
      cyc();
      tick(16'h0000, 1'b0, 2'd0);
      set_en(2'd0, 1'b1);
      tick(16'h0000, 1'b1, 2'd0);

      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
